// File: rtl/sample_avg_pkg.sv
// Shared types, limits and helpers for the sample_avg_16bits block-averaging front end.
// Optional build macro used by the top level: SAMPLE_AVG_ROUND_EN (round half-up instead of truncate).
package sample_avg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    localparam int LOG2_N_MIN = 1;
    localparam int LOG2_N_MAX = 8;

    // Accumulator width that holds the sum of 2^log2n full-scale samples without overflow
    function automatic int acc_width(input int dw, input int log2n);
        return dw + log2n;
    endfunction

endpackage

// File: rtl/avg_accum.sv
// Accumulator and sample counter for one block of 2^LOG2_N samples.
// load starts a new block with the sample, add folds a sample in, clear empties everything.
module avg_accum
    import sample_avg_pkg::*;
#(
    parameter int DW     = 16,
    parameter int LOG2_N = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic                                 add,
    input  logic                                 clear,
    input  logic [DW-1:0]                        sample,
    output logic [acc_width(DW, LOG2_N)-1:0]     acc,
    output logic                                 last
);

    localparam int AW = acc_width(DW, LOG2_N);
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'((1 << LOG2_N) - 1);

    logic [AW-1:0]     acc_d, acc_q;
    logic [LOG2_N-1:0] cnt_d, cnt_q;

    // Next accumulator/counter value; clear wins over load and add, the counter wraps naturally
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (load) begin
            acc_d = AW'(sample);
            cnt_d = LOG2_N'(1);
        end else if (add) begin
            acc_d = acc_q + AW'(sample);
            cnt_d = cnt_q + LOG2_N'(1);
        end
    end

    // Accumulator and counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sample_avg_16bits.sv
// Block-averaging front end for the 16-bit comparator: sums 2^LOG2_N accepted samples,
// then spends one EMIT cycle publishing the average on a registered output with a one-cycle strobe.
// Build macro SAMPLE_AVG_ROUND_EN: when defined the average rounds half-up, otherwise it truncates.
module sample_avg_16bits
    import sample_avg_pkg::*;
#(
    parameter int LOG2_N = 3,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in,
    output logic          in_ready,
    output logic [DW-1:0] out,
    output logic          out_valid
);

    localparam int AW = acc_width(DW, LOG2_N);

    if (LOG2_N < LOG2_N_MIN || LOG2_N > LOG2_N_MAX) begin : g_bad_log2n
        $error("sample_avg_16bits: LOG2_N out of range 1..8");
    end

    if (DW != 16) begin : g_bad_dw
        $error("sample_avg_16bits: DW must be 16 to match the comparator");
    end

    state_t          state_d, state_q;
    logic [DW-1:0]   out_d, out_q;
    logic            out_valid_d, out_valid_q;
    logic            acc_load, acc_add, acc_clear, acc_last;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_rounded;
    logic            accept;

    avg_accum #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .load   (acc_load),
        .add    (acc_add),
        .clear  (acc_clear),
        .sample (in),
        .acc    (acc),
        .last   (acc_last)
    );

`ifdef SAMPLE_AVG_ROUND_EN
    assign acc_rounded = acc + AW'(1 << (LOG2_N - 1));
`else
    assign acc_rounded = acc;
`endif

    assign in_ready = (state_q != ST_EMIT);
    assign accept   = in_valid && in_ready;

    // Next state, accumulator controls and output register update; clr overrides every transition
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        acc_load    = 1'b0;
        acc_add     = 1'b0;
        acc_clear   = 1'b0;
        if (clr) begin
            state_d   = ST_IDLE;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        acc_load = 1'b1;
                        state_d  = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_add = 1'b1;
                        if (acc_last) begin
                            state_d = ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    out_d       = acc_rounded[AW-1:LOG2_N];
                    out_valid_d = 1'b1;
                    acc_clear   = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    acc_clear = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sample_avg_16bits.sv
// Self-checking bench for sample_avg_16bits (default LOG2_N = 3, N = 8).
// Expected averages are queued when a block is issued; a monitor pops one per strobe.
// Honours SAMPLE_AVG_ROUND_EN so the same bench covers both output builds.
module tb_sample_avg_16bits;

`ifdef SAMPLE_AVG_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        clr      = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = 16'h0000;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_out = 16'h0000;

    sample_avg_16bits #(
        .LOG2_N (3),
        .DW     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in        (in_data),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Compare one value and log it on mismatch
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
        end
    endtask

    // Offer one sample and hold it until the DUT accepts it (bounded wait)
    task automatic applyStimulus(input logic [15:0] v);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Offer n copies of the same sample
    task automatic sendConst(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(v);
        end
    endtask

    // Let any pending strobe come out
    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued average
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_strobe: got out=0x%04h expected no strobe", out);
            end else begin
                checkOutput("strobe_out", out, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out", out, 16'h0000);
        checkOutput("reset_valid", 16'(out_valid), 16'h0000);
        checkOutput("reset_ready", 16'(in_ready), 16'h0001);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic average with latency and strobe-width checks
        $display("[TB] basic average");
        exp_q.push_back(16'h0048);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(16'(16 * i));
        end
        checkOutput("emit_valid_low", 16'(out_valid), 16'h0000);
        checkOutput("emit_ready_low", 16'(in_ready), 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("latency_strobe", 16'(out_valid), 16'h0001);
        checkOutput("latency_out", out, 16'h0048);
        @(posedge clk);
        #1;
        checkOutput("strobe_width", 16'(out_valid), 16'h0000);
        checkOutput("basic_hold", out, 16'h0048);
        last_out = 16'h0048;

        // Asynchronous reset mid-block
        $display("[TB] reset mid-block");
        sendConst(16'h0100, 5);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_out", out, 16'h0000);
        checkOutput("async_reset_valid", 16'(out_valid), 16'h0000);
        checkOutput("async_reset_ready", 16'(in_ready), 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(16'h0100);
        sendConst(16'h0100, 8);
        settle();
        checkOutput("after_reset_out", out, 16'h0100);

        // Full scale then all zero
        $display("[TB] full scale");
        exp_q.push_back(16'hFFFF);
        sendConst(16'hFFFF, 8);
        settle();
        checkOutput("full_scale_hold", out, 16'hFFFF);
        exp_q.push_back(16'h0000);
        sendConst(16'h0000, 8);
        settle();
        checkOutput("zero_hold", out, 16'h0000);

        // Rounding: sum 4 gives 0 truncated, 1 rounded
        $display("[TB] rounding");
        exp_q.push_back(ROUND_EN ? 16'h0001 : 16'h0000);
        applyStimulus(16'h0001);
        sendConst(16'h0000, 6);
        applyStimulus(16'h0003);
        settle();

        // Streaming: in_valid held high for 18 cycles, in = 0..17
        $display("[TB] streaming");
        exp_q.push_back(ROUND_EN ? 16'd4 : 16'd3);
        exp_q.push_back(ROUND_EN ? 16'd13 : 16'd12);
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            @(negedge clk);
            if (i == 8 || i == 17) begin
                checkOutput("stream_emit_ready", 16'(in_ready), 16'h0000);
            end else if (i == 0 || i == 9) begin
                checkOutput("stream_ready", 16'(in_ready), 16'h0001);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        settle();
        last_out = ROUND_EN ? 16'd13 : 16'd12;
        checkOutput("stream_hold", out, last_out);

        // clr mid-block with a sample on the same cycle: no strobe, out unchanged, sample discarded
        $display("[TB] clear mid-block");
        sendConst(16'h1000, 5);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hF000;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("clr_hold", out, last_out);
        exp_q.push_back(16'h0200);
        sendConst(16'h0200, 8);
        settle();
        checkOutput("clr_next_block", out, 16'h0200);
        last_out = 16'h0200;

        // clr during EMIT cancels the block
        $display("[TB] clear during emit");
        sendConst(16'h3000, 8);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        settle();
        checkOutput("clr_emit_hold", out, last_out);
        exp_q.push_back(16'h0020);
        sendConst(16'h0020, 8);
        settle();

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("scoreboard_drain", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_avg_16bits.md
Name: sample_avg_16bits

Overview:
- Block-averaging front end that sits directly upstream of the 16-bit comparator.
- Accepts a stream of 16-bit samples and sums each block of 2^LOG2_N accepted samples.
- Drives the block average on a registered 16-bit output that feeds the comparator's `in` input.
- A one-cycle strobe marks each new average, so the comparator sees a noise-reduced value instead of raw samples.

Parameters:
- LOG2_N, 3, log2 of samples per block (N = 8 by default); legal range 1..8.
- DW, 16, sample and result width; fixed at 16 for comparator compatibility.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; discards the partial block.
- in_valid  input  1  sample present on `in`.
- in  input  16  unsigned sample.
- in_ready  output  1  block accepts a sample this cycle.
- out  output  16  last block average, unsigned; drives the comparator `in`.
- out_valid  output  1  one-cycle strobe: `out` just updated.

Behaviour:
- Clock and reset:
  - One clock domain, `clk`.
  - `rst` is asynchronous and active-low.
  - While `rst` = 0: state = IDLE, acc = 0, cnt = 0, out = 0x0000, out_valid = 0.
- Accumulator width: acc is DW+LOG2_N bits (19 by default) and can never overflow.
- Counter width: cnt is LOG2_N bits.
- Sample acceptance: a sample is accepted on a rising edge where in_valid = 1 and in_ready = 1.
- in_ready is combinational: 1 in IDLE and ACCUM, 0 in EMIT.
- State IDLE:
  - On accept: acc <= in, cnt <= 1, go to ACCUM.
- State ACCUM:
  - On accept: acc <= acc + in, cnt <= cnt + 1.
  - If the accepted sample is the Nth (cnt == N-1): go to EMIT, and cnt wraps to 0.
  - Without accept: hold state, acc and cnt.
- State EMIT (exactly one cycle, in_ready = 0):
  - At the edge leaving EMIT: out <= acc >> LOG2_N, out_valid <= 1, acc <= 0, go to IDLE.
- Latency: the Nth sample is accepted at edge E; out and out_valid update at edge E+1; out_valid is high from E+1 to E+2 only.
- Back-to-back blocks:
  - A sample offered during EMIT is not accepted; the upstream source must hold or drop it.
  - Peak throughput is N samples per N+1 cycles.
- Output hold: `out` keeps its value between strobes, and the comparator samples it at any time.
- out_valid is 0 in every cycle except the strobe cycle.
- clr:
  - Synchronous and overrides all state transitions: state = IDLE, acc = 0, cnt = 0, out_valid <= 0.
  - `out` holds its value.
  - clr in the EMIT cycle cancels that block; no strobe is produced.
  - A sample presented in a clr cycle is discarded.
- Reset mid-block: the asynchronous clear applies immediately, and the partial sum is lost.
- Boundary values:
  - All-0xFFFF input yields out = 0xFFFF.
  - All-zero input yields 0x0000.

Optional Feature:
- Macro: SAMPLE_AVG_ROUND_EN.
- Defined: out <= (acc + 2^(LOG2_N-1)) >> LOG2_N, i.e. round half-up.
  - The sum fits in DW+LOG2_N bits and the result never exceeds 0xFFFF, so no clamp is needed.
- Undefined: truncating shift, rounding toward zero.
- All other timing and behaviour are identical in both builds.

Decomposition:
- Package sample_avg_pkg contains:
  - State encoding constants: ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_EMIT = 2'd2.
  - LOG2_N_MIN = 1 and LOG2_N_MAX = 8, checked by an elaboration-time assertion.
  - Function acc_width(dw, log2n) returning dw+log2n.
- Sub-module avg_accum holds the accumulator and the sample counter. It has:
  - Inputs: load, add, clear, sample.
  - Outputs: acc, last, where last = cnt == N-1.
- The top level holds the FSM, the output register and the rounding logic.

Test Plan:
- Reset: release rst, then send 5 samples and assert rst = 0 asynchronously mid-block -> out = 0x0000, out_valid = 0 immediately. After release, 8 samples of 0x0100 -> out = 0x0100.
- Basic average: 8 samples 0x0010, 0x0020, ..., 0x0080 (sum 0x240) -> out = 0x0048; out_valid high exactly one cycle, at edge E+1 after the 8th accept.
- Full scale: 8 samples of 0xFFFF -> out = 0xFFFF; no wrap. Then 8 samples of 0x0000 -> out = 0x0000.
- Rounding: samples 1,0,0,0,0,0,0,3 (sum 4) -> out = 0x0000 without SAMPLE_AVG_ROUND_EN; out = 0x0001 with it.
- Streaming: in_valid held high for 18 cycles with in = 0..17 -> first out = 3 (sum 28); sample 8 is rejected (in_ready = 0 during EMIT); second out = 12 (samples 9..16, sum 100).
- Clear: 5 samples of 0x1000, then clr for one cycle -> no strobe and out unchanged. Then 8 samples of 0x0200 -> out = 0x0200.
